cnt_seq_checker: RTL and testbench
==================================

Name: cnt_seq_checker

Overview:
- Receive-side monitor for the 4-bit free-running counter stream (CNT) driven by the counter block.
- Samples the incoming value each qualified clock and locks onto the +1 modulo-2^WIDTH sequence.
- Once locked, flags every out-of-sequence sample, counts the errors, and drops lock after repeated misses.
- Sits downstream of the counter, in place of the file-dump bench, as synthesizable self-checking hardware.

Parameters:
- WIDTH, 4, bit width of the monitored counter value.
- LOCK_CNT, 3, number of consecutive in-sequence samples (first sample included) needed to assert lock; must be ≥ 2.
- UNLOCK_CNT, 2, number of consecutive mismatches while locked that force loss of lock; must be ≥ 1.
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- EN  input  1  sample qualifier; CNT_IN is consumed only on edges where EN=1.
- CNT_IN  input  WIDTH  counter value under test.
- CLR  input  1  synchronous clear of ERR_CNT.
- LOCKED  output  1  high while the checker is in LOCK.
- ERR  output  1  one-cycle pulse per mismatched sample while in LOCK.
- ERR_CNT  output  ERR_W  saturating count of ERR pulses.
- EXP  output  WIDTH  next expected value.

Behaviour:
- Reset (nRST=0, asynchronous, immediate, including mid-operation):
  - state=SEARCH; LOCKED=0, ERR=0, ERR_CNT=0, EXP=0.
  - Internal run and miss counters = 0.
- All outputs are registered; each takes effect one edge after the sample that causes it.
- EN=0 edge: state, EXP, run, miss and ERR_CNT hold; ERR=0; CNT_IN is ignored.
- Every sampled edge deasserts ERR unless that edge itself raises an error.
- SEARCH, on a sample: EXP<=CNT_IN+1, run<=1, go to ACQ. No ERR.
- ACQ, on a sample:
  - CNT_IN==EXP: EXP<=CNT_IN+1, run<=run+1. If run+1==LOCK_CNT, go to LOCK, LOCKED<=1, miss<=0.
  - Mismatch: resync with EXP<=CNT_IN+1 and run<=1; stay in ACQ. No ERR and no count in ACQ.
- LOCK, on a sample:
  - Match: EXP<=EXP+1, miss<=0.
  - Mismatch: ERR<=1; ERR_CNT<=ERR_CNT+1 unless already all-ones; EXP<=EXP+1 (flywheel, no resync to the bad value); miss<=miss+1.
  - If miss+1==UNLOCK_CNT: go to SEARCH, LOCKED<=0, run<=0, miss<=0. ERR still pulses for this sample.
- Arithmetic:
  - EXP increments modulo 2^WIDTH, so 15→0 is in-sequence for WIDTH=4.
  - ERR_CNT saturates at 2^ERR_W−1 and never wraps.
- CLR:
  - CLR=1 forces ERR_CNT<=0 regardless of EN.
  - CLR wins over a simultaneous error: ERR still pulses, but ERR_CNT becomes 0.
  - CLR does not affect state, LOCKED, EXP or ERR.
- Outputs in SEARCH and ACQ: LOCKED=0 and ERR=0 always.

Test Plan:
- Lock acquisition: reset, then EN=1 with CNT_IN 0,1,2 → LOCKED=1 after the third edge, EXP=3, ERR never asserted, ERR_CNT=0.
- Wrap-around: locked, feed 13,14,15,0,1 → no ERR, LOCKED stays 1, EXP=2 at the end.
- Single glitch: locked with EXP=5, feed 9 then 6,7 → ERR high for exactly one cycle, ERR_CNT=1, EXP 6 then 7 then 8, LOCKED stays 1.
- Loss and relock: locked with EXP=4, feed 9 then 11 → two ERR pulses, ERR_CNT=2, LOCKED=0 after the second edge; then feed 7,8,9 → LOCKED=1, ERR_CNT holds at 2.
- EN gaps and CLR: locked, EN=0 for 3 cycles with CNT_IN=0xA → all outputs hold and ERR=0. Then EN=1 with a mismatch and CLR=1 on the same edge → ERR pulses and ERR_CNT=0.
- Saturation and async reset: with ERR_W=2, generate 5 locked mismatches, alternating good samples so lock is not dropped → ERR_CNT stops at 3. Then pull nRST low between clock edges → LOCKED, ERR, ERR_CNT and EXP go to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/cnt_seq_checker.sv
// -----------------------------------------------------------------------------
// cnt_seq_checker
//
// Receive-side monitor for a free-running WIDTH-bit counter stream. It locks
// onto the +1 (modulo 2^WIDTH) sequence after LOCK_CNT consecutive in-sequence
// samples. Once locked, it flags every out-of-sequence sample and keeps a
// saturating count of them. It drops lock after UNLOCK_CNT consecutive misses.
// While locked the expected value free-runs (flywheel), so a single bad sample
// does not re-align the checker to the corrupted value.
//
// Ports:
//   CLK      in   system clock, rising-edge
//   nRST     in   asynchronous active-low reset
//   EN       in   sample qualifier; CNT_IN is consumed only when EN=1
//   CNT_IN   in   [WIDTH-1:0] counter value under test
//   CLR      in   synchronous clear of ERR_CNT (independent of EN)
//   LOCKED   out  high while in LOCK
//   ERR      out  one-cycle pulse per mismatched sample while locked
//   ERR_CNT  out  [ERR_W-1:0] saturating count of ERR pulses
//   EXP      out  [WIDTH-1:0] next expected value
// -----------------------------------------------------------------------------
module cnt_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             EN,
  input  logic [WIDTH-1:0] CNT_IN,
  input  logic             CLR,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [WIDTH-1:0] EXP
);

  // Counters are sized to hold their terminal values exactly.
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [RUN_W-1:0]  LOCK_V   = RUN_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] UNLOCK_V = MISS_W'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

  logic                in_seq;
  logic [WIDTH-1:0]    cnt_next;
  logic [RUN_W-1:0]    run_inc;
  logic [MISS_W-1:0]   miss_inc;

  assign in_seq   = (CNT_IN == exp_q);
  assign cnt_next = CNT_IN + WIDTH'(1);
  assign run_inc  = run_q + RUN_W'(1);
  assign miss_inc = miss_q + MISS_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    exp_d     = exp_q;
    run_d     = run_q;
    miss_d    = miss_q;
    locked_d  = locked_q;
    err_d     = 1'b0;      // ERR is a pulse: cleared unless raised this edge
    err_cnt_d = err_cnt_q;

    if (EN) begin
      unique case (state_q)
        SEARCH: begin
          exp_d   = cnt_next;
          run_d   = RUN_W'(1);
          state_d = ACQ;
        end

        ACQ: begin
          // While acquiring, always follow the incoming stream.
          exp_d = cnt_next;
          if (in_seq) begin
            run_d = run_inc;
            if (run_inc == LOCK_V) begin
              state_d  = LOCK;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            run_d = RUN_W'(1);
          end
        end

        LOCK: begin
          // Flywheel: advance the expectation regardless of what arrived.
          exp_d = exp_q + WIDTH'(1);
          if (in_seq) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (miss_inc == UNLOCK_V) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              run_d    = '0;
              miss_d   = '0;
            end
          end
        end

        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          run_d    = '0;
          miss_d   = '0;
        end
      endcase
    end

    // Clear takes priority over any increment on the same edge.
    if (CLR) begin
      err_cnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= SEARCH;
      exp_q     <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign LOCKED  = locked_q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
  assign EXP     = exp_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq_checker
//
// Drives two checker instances from the same stimulus. One uses the default
// 8-bit error counter and the other a 2-bit error counter, so that saturation
// can be observed. The bench runs in three phases:
//   1. a directed vector table (lock, wrap, glitch, loss/relock, EN gaps, CLR);
//   2. hand-written sequences for saturation and asynchronous reset;
//   3. randomized stimulus compared against a reference model.
// -----------------------------------------------------------------------------
module tb_cnt_seq_checker;

  localparam int WIDTH      = 4;
  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 2;
  localparam int MOD        = 1 << WIDTH;

  logic             CLK;
  logic             nRST;
  logic             EN;
  logic [WIDTH-1:0] CNT_IN;
  logic             CLR;

  logic             locked_a, err_a;
  logic [7:0]       err_cnt_a;
  logic [WIDTH-1:0] exp_a;
  logic             locked_b, err_b;
  logic [1:0]       err_cnt_b;
  logic [WIDTH-1:0] exp_b;

  int n_checks = 0;
  int n_errors = 0;

  cnt_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .CNT_IN(CNT_IN), .CLR(CLR),
    .LOCKED(locked_a), .ERR(err_a), .ERR_CNT(err_cnt_a), .EXP(exp_a)
  );

  cnt_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(2)) dut_sat (
    .CLK(CLK), .nRST(nRST), .EN(EN), .CNT_IN(CNT_IN), .CLR(CLR),
    .LOCKED(locked_b), .ERR(err_b), .ERR_CNT(err_cnt_b), .EXP(exp_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare every output of both instances against one set of expectations.
  task automatic check_all(input string tag, input int lk, input int er,
                           input int c8, input int c2, input int ex);
    check({tag, ".LOCKED"},       32'(locked_a),  32'(lk));
    check({tag, ".ERR"},          32'(err_a),     32'(er));
    check({tag, ".ERR_CNT"},      32'(err_cnt_a), 32'(c8));
    check({tag, ".EXP"},          32'(exp_a),     32'(ex));
    check({tag, ".sat.LOCKED"},   32'(locked_b),  32'(lk));
    check({tag, ".sat.ERR"},      32'(err_b),     32'(er));
    check({tag, ".sat.ERR_CNT"},  32'(err_cnt_b), 32'(c2));
    check({tag, ".sat.EXP"},      32'(exp_b),     32'(ex));
  endtask

  // Apply one sample, then wait until just after the edge that consumes it.
  task automatic cycle(input logic en, input logic [WIDTH-1:0] cnt, input logic clr);
    EN     = en;
    CNT_IN = cnt;
    CLR    = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    EN = 1'b0; CNT_IN = '0; CLR = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic             en;
    logic [WIDTH-1:0] cnt;
    logic             clr;
    int               locked;
    int               err;
    int               cnt8;
    int               cnt2;
    int               exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input int cnt, input logic clr,
                              input int lk, input int er, input int c8,
                              input int c2, input int ex);
    vec_t v;
    v.en = en; v.cnt = WIDTH'(cnt); v.clr = clr;
    v.locked = lk; v.err = er; v.cnt8 = c8; v.cnt2 = c2; v.exp = ex;
    vecs.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model. It works from the stream rules directly: how many
  // consecutive good samples have been seen, how many consecutive misses have
  // occurred, and what value the stream should carry next.
  // ---------------------------------------------------------------------------
  bit m_locked;      // checker has locked onto the stream
  bit m_seen;        // at least one sample consumed since reset/unlock
  int m_good;        // consecutive in-sequence samples while acquiring
  int m_bad;         // consecutive misses while locked
  int m_next;        // value the stream should carry next
  int m_cnt8, m_cnt2;
  bit m_err;

  function automatic void model_reset();
    m_locked = 0; m_seen = 0; m_good = 0; m_bad = 0; m_next = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit en, input int cnt, input bit clr);
    m_err = 0;
    if (en) begin
      if (m_locked) begin
        if (cnt == m_next) begin
          m_bad = 0;
        end else begin
          m_err  = 1;
          m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
          m_bad++;
          if (m_bad >= UNLOCK_CNT) begin
            m_locked = 0; m_seen = 0; m_good = 0; m_bad = 0;
          end
        end
        m_next = (m_next + 1) % MOD;
      end else begin
        m_good = (m_seen && cnt == m_next) ? m_good + 1 : 1;
        m_seen = 1;
        m_next = (cnt + 1) % MOD;
        if (m_good >= LOCK_CNT) begin
          m_locked = 1; m_bad = 0;
        end
      end
    end
    if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int x;

    nRST = 1'b1; EN = 1'b0; CNT_IN = '0; CLR = 1'b0;

    // Table: lock, glitch, wrap, loss/relock, EN gap, CLR vs error.
    add(1, 0, 0,  0, 0, 0, 0, 1);
    add(1, 1, 0,  0, 0, 0, 0, 2);
    add(1, 2, 0,  1, 0, 0, 0, 3);     // lock after third sample
    add(1, 3, 0,  1, 0, 0, 0, 4);
    add(1, 4, 0,  1, 0, 0, 0, 5);
    add(1, 9, 0,  1, 1, 1, 1, 6);     // single glitch, EXP flywheels
    add(1, 6, 0,  1, 0, 1, 1, 7);
    add(1, 7, 0,  1, 0, 1, 1, 8);
    for (int v = 8; v <= 17; v++)     // through 15 -> 0 wrap
      add(1, v % MOD, 0, 1, 0, 1, 1, (v + 1) % MOD);
    add(1, 2, 0,  1, 0, 1, 1, 3);
    add(1, 3, 0,  1, 0, 1, 1, 4);
    add(1, 9, 0,  1, 1, 2, 2, 5);     // first miss
    add(1, 11, 0, 0, 1, 3, 3, 6);     // second miss drops lock
    add(1, 7, 0,  0, 0, 3, 3, 8);     // reacquire
    add(1, 8, 0,  0, 0, 3, 3, 9);
    add(1, 9, 0,  1, 0, 3, 3, 10);
    add(0, 10, 0, 1, 0, 3, 3, 10);    // EN gap: everything holds
    add(0, 10, 0, 1, 0, 3, 3, 10);
    add(0, 10, 0, 1, 0, 3, 3, 10);
    add(1, 0, 1,  1, 1, 0, 0, 11);    // error with CLR: pulse, count 0
    add(1, 11, 0, 1, 0, 0, 0, 12);
    add(1, 5, 0,  1, 1, 1, 1, 13);    // count again, then clear with EN=0
    add(0, 5, 1,  1, 0, 0, 0, 13);
    add(1, 13, 0, 1, 0, 0, 0, 14);

    do_reset();
    #1;
    check_all("reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].cnt, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].locked, vecs[i].err,
                vecs[i].cnt8, vecs[i].cnt2, vecs[i].exp);
    end

    // Saturation: locked with EXP=14, five misses separated by good samples.
    x = 14;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, WIDTH'((x + 5) % MOD), 1'b0);
      x = (x + 1) % MOD;
      check_all($sformatf("sat_bad%0d", i), 1, 1, i + 1, (i + 1 < 3) ? i + 1 : 3, x);
      cycle(1'b1, WIDTH'(x), 1'b0);
      x = (x + 1) % MOD;
      check_all($sformatf("sat_good%0d", i), 1, 0, i + 1, (i + 1 < 3) ? i + 1 : 3, x);
    end

    // Asynchronous reset between edges, checked before any further edge.
    cycle(1'b1, WIDTH'((x + 3) % MOD), 1'b0);   // leave ERR high
    x = (x + 1) % MOD;
    check_all("pre_areset", 1, 1, 6, 3, x);
    #2;
    nRST = 1'b0;
    #1;
    check_all("areset", 0, 0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Randomized phase against the reference model.
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      logic             en, clr;
      logic [WIDTH-1:0] cnt;
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 31) == 0);
      cnt = ($urandom_range(0, 4) != 0) ? WIDTH'(m_next) : WIDTH'($urandom_range(0, MOD - 1));
      cycle(en, cnt, clr);
      model_step(en, int'(cnt), clr);
      check_all($sformatf("rnd%0d", i), int'(m_locked), int'(m_err), m_cnt8, m_cnt2, m_next);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
